inst_queue_nwide: RTL and testbench

- Parametrised successor of the ID-stage instruction queue.
- Accepts up to FETCH_W contiguous fetched instruction packets per cycle from IF and presents the oldest ISSUE_W packets to the issue decoder.
- Pops 0..ISSUE_W packets per cycle as the decoder commits them.
- Adds an explicit enqueue ready handshake, a combinational valid mask with no stale-count cycle, a configurable stop-fetch margin and a dequeue clamp.

---
 rtl/inst_queue_nwide_pkg.sv | 30 +++
 rtl/iq_multiport_ring.sv | 41 ++++
 rtl/inst_queue_nwide.sv | 92 +++++++++
 tb/tb_inst_queue_nwide.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_nwide_pkg.sv
// Shared definitions for the N-wide ID-stage instruction queue: packet field
// layout and default geometry.
package inst_queue_nwide_pkg;

  localparam int IQ_VADDR_W      = 32;
  localparam int IQ_INST_W       = 32;
  localparam int IQ_ISREFILL_W   = 1;
  localparam int IQ_EXCCODE_W    = 5;
  localparam int IQ_HASEXC_W     = 1;
  localparam int IQ_CHECKPOINT_W = 16;
  localparam int IQ_PREDTAKE_W   = 1;
  localparam int IQ_PREDDEST_W   = 32;

  // Packet is {predDest, predTake, checkpoint, hasExc, excCode, isRefill, inst, vaddr}, vaddr at bit 0
  localparam int IQ_VADDR_OFF      = 0;
  localparam int IQ_INST_OFF       = IQ_VADDR_OFF + IQ_VADDR_W;
  localparam int IQ_ISREFILL_OFF   = IQ_INST_OFF + IQ_INST_W;
  localparam int IQ_EXCCODE_OFF    = IQ_ISREFILL_OFF + IQ_ISREFILL_W;
  localparam int IQ_HASEXC_OFF     = IQ_EXCCODE_OFF + IQ_EXCCODE_W;
  localparam int IQ_CHECKPOINT_OFF = IQ_HASEXC_OFF + IQ_HASEXC_W;
  localparam int IQ_PREDTAKE_OFF   = IQ_CHECKPOINT_OFF + IQ_CHECKPOINT_W;
  localparam int IQ_PREDDEST_OFF   = IQ_PREDTAKE_OFF + IQ_PREDTAKE_W;
  localparam int IQ_ENTRY_W        = IQ_PREDDEST_OFF + IQ_PREDDEST_W;

  localparam int IQ_FETCH_W     = 4;
  localparam int IQ_ISSUE_W     = 2;
  localparam int IQ_DEPTH       = 16;
  localparam int IQ_STOP_MARGIN = 11;

endpackage

// File: rtl/iq_multiport_ring.sv
// Unreset DEPTH-entry packet store with FETCH_W contiguous write lanes and
// ISSUE_W contiguous combinational read lanes; indices wrap modulo DEPTH.
module iq_multiport_ring #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 120,
  parameter int FETCH_W = 4,
  parameter int ISSUE_W = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int NW     = $clog2(FETCH_W + 1)
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [AW-1:0]              wr_base_i,
  input  logic [NW-1:0]              wr_num_i,
  input  logic [FETCH_W*ENTRY_W-1:0] wr_data_i,
  input  logic [AW-1:0]              rd_base_i,
  output logic [ISSUE_W*ENTRY_W-1:0] rd_data_o
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [FETCH_W-1:0] lane_en;
  logic [AW-1:0]      wr_idx [FETCH_W];
  logic [AW-1:0]      rd_idx [ISSUE_W];

  for (genvar g = 0; g < FETCH_W; g++) begin : g_wr
    assign lane_en[g] = we_i && (wr_num_i > NW'(g));
    assign wr_idx[g]  = wr_base_i + AW'(g);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (lane_en[i]) mem[wr_idx[i]] <= wr_data_i[i*ENTRY_W +: ENTRY_W];
    end
  end

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_rd
    assign rd_idx[g] = rd_base_i + AW'(g);
    assign rd_data_o[g*ENTRY_W +: ENTRY_W] = mem[rd_idx[g]];
  end

endmodule

// File: rtl/inst_queue_nwide.sv
// N-wide instruction queue between IF and the issue decoder: wrap-bit pointers,
// enqueue handshake, dequeue clamp, flush and fetch throttle.
module inst_queue_nwide
  import inst_queue_nwide_pkg::*;
#(
  parameter int FETCH_W     = IQ_FETCH_W,
  parameter int ISSUE_W     = IQ_ISSUE_W,
  parameter int DEPTH       = IQ_DEPTH,
  parameter int ENTRY_W     = IQ_ENTRY_W,
  parameter int STOP_MARGIN = IQ_STOP_MARGIN,
  localparam int AW         = $clog2(DEPTH),
  localparam int PW         = $clog2(DEPTH) + 1,
  localparam int EN_W       = $clog2(FETCH_W + 1),
  localparam int DQ_W       = $clog2(ISSUE_W + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  input  logic [EN_W-1:0]            enq_num_i,
  input  logic [FETCH_W*ENTRY_W-1:0] enq_data_i,
  output logic                       enq_ready_o,
  input  logic [DQ_W-1:0]            deq_num_i,
  output logic [ISSUE_W-1:0]         deq_valid_o,
  output logic [ISSUE_W*ENTRY_W-1:0] deq_data_o,
  output logic [PW-1:0]              count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       stop_fetch_o
);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] count;
  logic [PW-1:0] deq_req;
  logic [PW-1:0] deq_eff;
  logic [PW-1:0] enq_n;
  logic          enq_fire;

  assign count       = tail_q - head_q;
  assign enq_ready_o = (PW'(DEPTH) - count) >= PW'(FETCH_W);
  assign enq_fire    = enq_valid_i & enq_ready_o & ~flush_i;
  assign enq_n       = enq_fire ? PW'(enq_num_i) : '0;

  // The decoder may ask for more than is held; never let head pass tail.
  assign deq_req = PW'(deq_num_i);
  assign deq_eff = flush_i ? '0 : ((deq_req > count) ? count : deq_req);

  always_comb begin
    head_d = head_q + deq_eff;
    tail_d = tail_q + enq_n;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  iq_multiport_ring #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .FETCH_W (FETCH_W),
    .ISSUE_W (ISSUE_W)
  ) u_ring (
    .clk       (clk),
    .we_i      (enq_fire & rst),
    .wr_base_i (tail_q[AW-1:0]),
    .wr_num_i  (enq_num_i),
    .wr_data_i (enq_data_i),
    .rd_base_i (head_q[AW-1:0]),
    .rd_data_o (deq_data_o)
  );

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_vld
    assign deq_valid_o[g] = count > PW'(g);
  end

  assign count_o      = count;
  assign full_o       = count == PW'(DEPTH);
  assign empty_o      = count == '0;
  assign stop_fetch_o = (count >= PW'(DEPTH - STOP_MARGIN)) & ~flush_i;

endmodule

// File: tb/tb_inst_queue_nwide.sv
// Directed bench for inst_queue_nwide: each task drives one scenario and
// compares outputs against hand-derived values.
module tb_inst_queue_nwide;

  localparam int FETCH_W = 4;
  localparam int ISSUE_W = 2;
  localparam int DEPTH   = 16;
  localparam int ENTRY_W = 120;
  localparam int EN_W    = $clog2(FETCH_W + 1);
  localparam int DQ_W    = $clog2(ISSUE_W + 1);
  localparam int PW      = $clog2(DEPTH) + 1;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       flush_i = 1'b0;
  logic                       enq_valid_i = 1'b0;
  logic [EN_W-1:0]            enq_num_i = '0;
  logic [FETCH_W*ENTRY_W-1:0] enq_data_i = '0;
  logic                       enq_ready_o;
  logic [DQ_W-1:0]            deq_num_i = '0;
  logic [ISSUE_W-1:0]         deq_valid_o;
  logic [ISSUE_W*ENTRY_W-1:0] deq_data_o;
  logic [PW-1:0]              count_o;
  logic                       full_o;
  logic                       empty_o;
  logic                       stop_fetch_o;

  int checks = 0;
  int errors = 0;

  inst_queue_nwide #(
    .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .STOP_MARGIN(11)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_num_i(enq_num_i), .enq_data_i(enq_data_i),
    .enq_ready_o(enq_ready_o), .deq_num_i(deq_num_i), .deq_valid_o(deq_valid_o),
    .deq_data_o(deq_data_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .stop_fetch_o(stop_fetch_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && enq_valid_i)
      assert (32'(enq_num_i) <= FETCH_W) else $error("illegal enq_num_i %0d", enq_num_i);
    if (rst && !flush_i && (32'(deq_num_i) > 32'(count_o)))
      $display("note: deq_num_i %0d exceeds count %0d, clamped", deq_num_i, count_o);
  end

  function automatic logic [ENTRY_W-1:0] mk(input logic [15:0] tag);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[15:0] = tag;
    e[63:48] = tag ^ 16'h5A5A;
    e[ENTRY_W-1 -: 16] = ~tag;
    return e;
  endfunction

  function automatic logic [ENTRY_W-1:0] lane(input int i);
    return deq_data_o[i*ENTRY_W +: ENTRY_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer n packets tagged t0, t0+1, ... and request dq pops.
  task automatic drive(input logic v, input int n, input logic [15:0] t0, input int dq);
    enq_valid_i = v;
    enq_num_i   = EN_W'(n);
    for (int i = 0; i < FETCH_W; i++) enq_data_i[i*ENTRY_W +: ENTRY_W] = mk(t0 + 16'(i));
    deq_num_i   = DQ_W'(dq);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 0, 16'h0, 0);
    tick();
    tick();
    rst = 1'b1;
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full_o); end
    checks++; if (enq_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", enq_ready_o); end
    checks++; if (deq_valid_o !== 2'b00) begin errors++; $display("FAIL rst_valid: got %b expected 00", deq_valid_o); end
    checks++; if (stop_fetch_o !== 1'b0) begin errors++; $display("FAIL rst_stop: got %b expected 0", stop_fetch_o); end
  endtask

  task automatic test_enq_deq();
    drive(1'b1, 4, 16'h00A0, 0);
    checks++; if (deq_valid_o !== 2'b00) begin errors++; $display("FAIL no_bypass: got %b expected 00", deq_valid_o); end
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (count_o !== 5'd4) begin errors++; $display("FAIL enq_count: got %0d expected 4", count_o); end
    checks++; if (deq_valid_o !== 2'b11) begin errors++; $display("FAIL enq_valid: got %b expected 11", deq_valid_o); end
    checks++; if (lane(0) !== mk(16'h00A0)) begin errors++; $display("FAIL enq_lane0: got %h expected %h", lane(0), mk(16'h00A0)); end
    checks++; if (lane(1) !== mk(16'h00A1)) begin errors++; $display("FAIL enq_lane1: got %h expected %h", lane(1), mk(16'h00A1)); end
    drive(1'b0, 0, 16'h0, 1);
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL deq1_count: got %0d expected 3", count_o); end
    checks++; if (lane(0) !== mk(16'h00A1)) begin errors++; $display("FAIL deq1_lane0: got %h expected %h", lane(0), mk(16'h00A1)); end
    checks++; if (lane(1) !== mk(16'h00A2)) begin errors++; $display("FAIL deq1_lane1: got %h expected %h", lane(1), mk(16'h00A2)); end
    drive(1'b0, 0, 16'h0, 2);
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (deq_valid_o !== 2'b01) begin errors++; $display("FAIL deq2_valid: got %b expected 01", deq_valid_o); end
    checks++; if (lane(0) !== mk(16'h00A3)) begin errors++; $display("FAIL deq2_lane0: got %h expected %h", lane(0), mk(16'h00A3)); end
    drive(1'b0, 0, 16'h0, 1);
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4, 16'h0010 + 16'(4*k), 0);
      tick();
      drive(1'b0, 0, 16'h0, 0);
      checks++; if (32'(count_o) !== 4*(k+1)) begin errors++; $display("FAIL fill_count%0d: got %0d expected %0d", k, count_o, 4*(k+1)); end
      checks++; if (stop_fetch_o !== (k >= 1)) begin errors++; $display("FAIL fill_stop%0d: got %b expected %b", k, stop_fetch_o, k >= 1); end
      checks++; if (enq_ready_o !== (k <= 2)) begin errors++; $display("FAIL fill_ready%0d: got %b expected %b", k, enq_ready_o, k <= 2); end
      checks++; if (full_o !== (k == 3)) begin errors++; $display("FAIL fill_full%0d: got %b expected %b", k, full_o, k == 3); end
    end
    drive(1'b1, 4, 16'h0050, 0);
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL overoffer_count: got %0d expected 16", count_o); end
    checks++; if (lane(0) !== mk(16'h0010)) begin errors++; $display("FAIL overoffer_lane0: got %h expected %h", lane(0), mk(16'h0010)); end
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 0, 16'h0, 2);
      checks++; if (lane(0) !== mk(16'h0010 + 16'(2*k))) begin errors++; $display("FAIL fdrain_lane0_%0d: got %h expected %h", k, lane(0), mk(16'h0010 + 16'(2*k))); end
      checks++; if (lane(1) !== mk(16'h0011 + 16'(2*k))) begin errors++; $display("FAIL fdrain_lane1_%0d: got %h expected %h", k, lane(1), mk(16'h0011 + 16'(2*k))); end
      tick();
    end
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fdrain_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 2, 16'h0100, 0);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 2, 16'h0102 + 16'(2*k), 2);
      tick();
      drive(1'b0, 0, 16'h0, 0);
      checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL wrap_count%0d: got %0d expected 2", k, count_o); end
      checks++; if (lane(0) !== mk(16'h0102 + 16'(2*k))) begin errors++; $display("FAIL wrap_lane0_%0d: got %h expected %h", k, lane(0), mk(16'h0102 + 16'(2*k))); end
      checks++; if (lane(1) !== mk(16'h0103 + 16'(2*k))) begin errors++; $display("FAIL wrap_lane1_%0d: got %h expected %h", k, lane(1), mk(16'h0103 + 16'(2*k))); end
    end
    drive(1'b0, 0, 16'h0, 2);
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty_o); end
  endtask

  task automatic test_flush();
    drive(1'b1, 4, 16'h0200, 0);
    tick();
    drive(1'b1, 3, 16'h0204, 0);
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (count_o !== 5'd7) begin errors++; $display("FAIL preflush_count: got %0d expected 7", count_o); end
    checks++; if (stop_fetch_o !== 1'b1) begin errors++; $display("FAIL preflush_stop: got %b expected 1", stop_fetch_o); end
    flush_i = 1'b1;
    drive(1'b1, 3, 16'h0300, 2);
    checks++; if (stop_fetch_o !== 1'b0) begin errors++; $display("FAIL flush_stop: got %b expected 0", stop_fetch_o); end
    tick();
    flush_i = 1'b0;
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", empty_o); end
    checks++; if (deq_valid_o !== 2'b00) begin errors++; $display("FAIL flush_valid: got %b expected 00", deq_valid_o); end
    drive(1'b1, 2, 16'h0400, 0);
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (lane(0) !== mk(16'h0400)) begin errors++; $display("FAIL postflush_lane0: got %h expected %h", lane(0), mk(16'h0400)); end
    checks++; if (lane(1) !== mk(16'h0401)) begin errors++; $display("FAIL postflush_lane1: got %h expected %h", lane(1), mk(16'h0401)); end
    drive(1'b0, 0, 16'h0, 2);
    tick();
    drive(1'b0, 0, 16'h0, 0);
  endtask

  task automatic test_clamp();
    drive(1'b1, 1, 16'h0500, 0);
    tick();
    drive(1'b0, 0, 16'h0, 2);
    checks++; if (deq_valid_o !== 2'b01) begin errors++; $display("FAIL clamp_pre_valid: got %b expected 01", deq_valid_o); end
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL clamp_count: got %0d expected 0", count_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL clamp_empty: got %b expected 1", empty_o); end
    drive(1'b1, 2, 16'h0600, 0);
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL clamp_refill_count: got %0d expected 2", count_o); end
    checks++; if (lane(0) !== mk(16'h0600)) begin errors++; $display("FAIL clamp_refill_lane0: got %h expected %h", lane(0), mk(16'h0600)); end
    drive(1'b1, 0, 16'h0700, 0);
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL enq0_count: got %0d expected 2", count_o); end
    checks++; if (lane(1) !== mk(16'h0601)) begin errors++; $display("FAIL enq0_lane1: got %h expected %h", lane(1), mk(16'h0601)); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    drive(1'b1, 4, 16'h0800, 1);
    tick();
    rst = 1'b1;
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count_o); end
    checks++; if (deq_valid_o !== 2'b00) begin errors++; $display("FAIL midrst_valid: got %b expected 00", deq_valid_o); end
    drive(1'b1, 2, 16'h0900, 0);
    tick();
    drive(1'b0, 0, 16'h0, 0);
    checks++; if (lane(0) !== mk(16'h0900)) begin errors++; $display("FAIL midrst_lane0: got %h expected %h", lane(0), mk(16'h0900)); end
    checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL midrst_refill_count: got %0d expected 2", count_o); end
  endtask

  initial begin
    test_reset();
    test_enq_deq();
    test_fill();
    test_wrap();
    test_flush();
    test_clamp();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
